// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: FSM encodings, defaults, master indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_arbiter_pkg;

    // Sequencer states: one cycle to strobe the ROM, a bounded wait, one cycle to acknowledge.
    typedef enum logic [1:0] {
        ROM_ARB_IDLE = 2'd0,
        ROM_ARB_REQ  = 2'd1,
        ROM_ARB_WAIT = 2'd2,
        ROM_ARB_RESP = 2'd3
    } rom_arb_state_t;

    // Default number of WAIT cycles tolerated before an access is aborted.
    localparam int ROM_ARB_TIMEOUT = 15;

    // Master indices: 0 = CPU instruction fetch, 1 = debug/loader.
    localparam logic ROM_ARB_M0 = 1'b0;
    localparam logic ROM_ARB_M1 = 1'b1;

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-input round-robin grant; on contention the master not granted last wins.
// Latency: combinational grant; last_grant updates on the clock edge that accepts a grant.
// Backpressure: grants are only taken (and history only updated) while en is high.
//
// Ports: clk, reset (sync, active high); req[1:0] request levels; en = caller is able to
// accept a grant this cycle; gnt_vld = some request present; gnt_idx = winning master.
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic last_grant;

    always_comb begin
        gnt_vld = |req;
        gnt_idx = ROM_ARB_M0;
        if (req[0] && req[1]) begin
            gnt_idx = ~last_grant;
        end else if (req[1]) begin
            gnt_idx = ROM_ARB_M1;
        end
    end

    // Reset to M1 so that M0 wins the very first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ROM_ARB_M1;
        end else if (en && gnt_vld) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Serialises two masters' reads onto the single-port instruction ROM with round-robin fairness.
// Latency: request-to-ack 3 cycles with an immediate ROM, 3+TIMEOUT cycles on timeout; 1 access / 4 cycles peak.
// Backpressure: masters hold req until their one-cycle ack; the ROM stalls via rdy_, bounded by TIMEOUT.
//
// Ports: clk, reset (sync, active high);
//   m0_/m1_ req, addr in; ack, err, rd_data out (registered, rd_data holds until the next ack);
//   rom_cs_, rom_as_ (active-low strobes, low for exactly one cycle per access), rom_addr out;
//   rom_rd_data, rom_rdy_ (active low, valid only while waiting) in.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ROM_ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              rom_cs_,
    output logic              rom_as_,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    input  logic              rom_rdy_
);

    // Sized to hold TIMEOUT itself; the counter stops there, so it can never wrap.
    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    rom_arb_state_t    state_q;
    rom_arb_state_t    state_d;
    logic              arb_en;
    logic              gnt_vld;
    logic              gnt_idx;
    logic              gnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_data;

    // Arbitrate only in IDLE: during an access (including RESP, where the acked
    // master still has req high) requests are not looked at.
    assign arb_en = (state_q == ROM_ARB_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     ({m1_req, m0_req}),
        .en      (arb_en),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ROM_ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus completion decode. ROM ready takes priority over the
    // timeout, so a response arriving in the last allowed cycle still succeeds.
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;
        case (state_q)
            ROM_ARB_IDLE: begin
                if (gnt_vld) begin
                    state_d = ROM_ARB_REQ;
                end
            end
            ROM_ARB_REQ: begin
                state_d = ROM_ARB_WAIT;
            end
            ROM_ARB_WAIT: begin
                if (!rom_rdy_) begin
                    done      = 1'b1;
                    done_data = rom_rd_data;
                    state_d   = ROM_ARB_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    state_d  = ROM_ARB_RESP;
                end
            end
            ROM_ARB_RESP: begin
                state_d = ROM_ARB_IDLE;
            end
            default: begin
                state_d = ROM_ARB_IDLE;
            end
        endcase
    end

    // Registered ROM-side and master-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q      <= ROM_ARB_M0;
            cnt_q      <= '0;
            rom_cs_    <= 1'b1;
            rom_as_    <= 1'b1;
            rom_addr   <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rd_data <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rd_data <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            rom_cs_ <= 1'b1;
            rom_as_ <= 1'b1;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;

            if ((state_q == ROM_ARB_IDLE) && gnt_vld) begin
                gnt_q    <= gnt_idx;
                rom_addr <= (gnt_idx == ROM_ARB_M1) ? m1_addr : m0_addr;
                rom_cs_  <= 1'b0;
                rom_as_  <= 1'b0;
            end

            if (state_q == ROM_ARB_REQ) begin
                cnt_q <= '0;
            end else if ((state_q == ROM_ARB_WAIT) && !done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Only the granted master's response registers move.
            if (done) begin
                if (gnt_q == ROM_ARB_M1) begin
                    m1_ack     <= 1'b1;
                    m1_err     <= done_err;
                    m1_rd_data <= done_data;
                end else begin
                    m0_ack     <= 1'b1;
                    m0_err     <= done_err;
                    m0_rd_data <= done_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: directed timing cases, then two randomised masters.
// Latency: n/a.
// Backpressure: n/a.
module tb_rom_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int TMO    = 15;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
        int                lat;     // cycles from strobe to ack
        int                ack_at;  // absolute ack cycle, -1 = not pinned
    } exp_t;

    logic              clk;
    logic              reset;
    logic [1:0]        req_v;
    logic [ADDR_W-1:0] addr_v [2];
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
    logic              rom_cs_, rom_as_;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rd_data;
    logic              rom_rdy_;

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (req_v[0]),
        .m0_addr     (addr_v[0]),
        .m0_ack      (m0_ack),
        .m0_err      (m0_err),
        .m0_rd_data  (m0_rd_data),
        .m1_req      (req_v[1]),
        .m1_addr     (addr_v[1]),
        .m1_ack      (m1_ack),
        .m1_err      (m1_err),
        .m1_rd_data  (m1_rd_data),
        .rom_cs_     (rom_cs_),
        .rom_as_     (rom_as_),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .rom_rdy_    (rom_rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DATA_W-1:0] rom_mem [1 << ADDR_W];
    exp_t              q0[$];
    exp_t              q1[$];
    bit   [1:0]        pend;
    int                req_t [2];
    logic [DATA_W-1:0] sh_data [2];
    logic              sh_err [2];
    int                last_served;
    bit                in_flight;
    bit                contend;
    int                strobe_cyc;
    logic [ADDR_W-1:0] strobe_addr;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // ROM address map used by the ROM model: 0x7xx never answers,
    // 0x6xx answers after addr[1:0]+1 extra cycles, everything else immediately.
    function automatic bit is_to(input logic [ADDR_W-1:0] a);
        return a[10:8] == 3'b111;
    endfunction

    function automatic int extra_of(input logic [ADDR_W-1:0] a);
        return (a[10:8] == 3'b110) ? int'(a[1:0]) + 1 : 0;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        logic [ADDR_W-1:0] a;
        r = $urandom_range(0, 7);
        a = ADDR_W'($urandom_range(0, 32'h5FF));
        if (r == 0) a[10:8] = 3'b111;
        else if (r == 1) a[10:8] = 3'b110;
        return a;
    endfunction

    // Called at a negedge: present the request and record what the master must get back.
    task automatic start_req(input int m, input logic [ADDR_W-1:0] a, input int ack_at);
        exp_t e;
        e.addr   = a;
        e.err    = is_to(a);
        e.data   = e.err ? '0 : rom_mem[a];
        e.lat    = e.err ? TMO + 2 : 2 + extra_of(a);
        e.ack_at = ack_at;
        req_v[m]  = 1'b1;
        addr_v[m] = a;
        pend[m]   = 1'b1;
        req_t[m]  = cyc;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ack(input int m);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = (m == 0) ? m0_ack : m1_ack;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_wait m%0d: got no ack want ack within 300 cycles", m);
        end
    endtask

    task automatic agent(input int m, input int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                req_v[m] = 1'b0;
                repeat (gap) @(negedge clk);
            end
            start_req(m, rand_addr(), -1);
            wait_ack(m);
            @(negedge clk);
        end
        req_v[m] = 1'b0;
    endtask

    task automatic handle_ack(input int m);
        exp_t e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack m%0d: got ack want none (cycle %0d)", m, cyc);
            return;
        end
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk("ack_in_flight", 64'(in_flight), 64'd1);
        chk("ack_data", 64'((m == 0) ? m0_rd_data : m1_rd_data), 64'(e.data));
        chk("ack_err", 64'((m == 0) ? m0_err : m1_err), 64'(e.err));
        chk("rom_addr", 64'(strobe_addr), 64'(e.addr));
        chk("latency", 64'(cyc - strobe_cyc), 64'(e.lat));
        if (e.ack_at >= 0) chk("ack_cycle", 64'(cyc), 64'(e.ack_at));
        if (contend) chk("rr_order", 64'(m), 64'(1 - last_served));
        last_served = m;
        sh_data[m]  = e.data;
        sh_err[m]   = e.err;
        pend[m]     = 1'b0;
        in_flight   = 1'b0;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        bit rst_e;
        forever begin
            @(posedge clk);
            cyc++;
            rst_e = reset;
            #1;
            if (rst_e) begin
                chk("rst_cs", 64'(rom_cs_), 64'd1);
                chk("rst_as", 64'(rom_as_), 64'd1);
                chk("rst_addr", 64'(rom_addr), 64'd0);
                chk("rst_ack", 64'({m1_ack, m0_ack}), 64'd0);
                q0.delete();
                q1.delete();
                pend        = '0;
                in_flight   = 1'b0;
                contend     = 1'b0;
                last_served = 1;
                sh_data[0]  = '0;
                sh_data[1]  = '0;
                sh_err[0]   = 1'b0;
                sh_err[1]   = 1'b0;
            end else begin
                chk("strobe_pair", 64'(rom_cs_), 64'(rom_as_));
                if (!rom_cs_) begin
                    chk("strobe_once", 64'(in_flight), 64'd0);
                    in_flight   = 1'b1;
                    strobe_cyc  = cyc;
                    strobe_addr = rom_addr;
                    contend = pend[0] && pend[1] && (req_t[0] <= cyc - 1) && (req_t[1] <= cyc - 1);
                end
                chk("ack_onehot", 64'(m0_ack & m1_ack), 64'd0);
                if (m0_ack) handle_ack(0);
                if (m1_ack) handle_ack(1);
            end
            chk("hold_data0", 64'(m0_rd_data), 64'(sh_data[0]));
            chk("hold_data1", 64'(m1_rd_data), 64'(sh_data[1]));
            chk("hold_err0", 64'(m0_err), 64'(sh_err[0]));
            chk("hold_err1", 64'(m1_err), 64'(sh_err[1]));
        end
    end

    // ROM model: rdy_ low one cycle after the strobe plus the address-dependent extra
    // delay; random stray rdy_ pulses whenever no access is outstanding.
    initial begin
        bit                rom_active;
        bit                rom_busy;
        int                rom_wait;
        logic [ADDR_W-1:0] rom_a;
        rom_active  = 1'b0;
        rom_busy    = 1'b0;
        rom_wait    = 0;
        rom_a       = '0;
        rom_rdy_    = 1'b1;
        rom_rd_data = '0;
        forever begin
            @(negedge clk);
            #1;
            rom_rdy_    = 1'b1;
            rom_rd_data = $urandom;
            if (reset) begin
                rom_active = 1'b0;
                rom_busy   = 1'b0;
            end else begin
                if (rom_active && (m0_ack || m1_ack)) rom_active = 1'b0;
                if (rom_busy) begin
                    if (rom_wait == 0) begin
                        rom_rdy_    = 1'b0;
                        rom_rd_data = rom_mem[rom_a];
                        rom_busy    = 1'b0;
                    end else begin
                        rom_wait--;
                    end
                end else if (!rom_active && $urandom_range(0, 5) == 0) begin
                    rom_rdy_ = 1'b0;
                end
                if (!rom_cs_ && !rom_as_) begin
                    rom_active = 1'b1;
                    rom_a      = rom_addr;
                    if (!is_to(rom_addr)) begin
                        rom_busy = 1'b1;
                        rom_wait = extra_of(rom_addr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = $urandom;
        rom_mem[16] = 32'hDEADBEEF;
        req_v     = '0;
        addr_v[0] = '0;
        addr_v[1] = '0;
        pend      = '0;
        req_t[0]  = 0;
        req_t[1]  = 0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Simultaneous requests, twice: m0 first both times.
        for (int r = 0; r < 2; r++) begin
            t = cyc;
            start_req(0, 11'h001, t + 3);
            start_req(1, 11'h002, t + 7);
            fork
                begin wait_ack(0); @(negedge clk); req_v[0] = 1'b0; end
                begin wait_ack(1); @(negedge clk); req_v[1] = 1'b0; end
            join
            @(negedge clk);
        end

        // Single request returning 0xDEADBEEF.
        t = cyc;
        start_req(0, 11'h010, t + 3);
        wait_ack(0);
        @(negedge clk);
        req_v[0] = 1'b0;
        @(negedge clk);

        // Timeout, then an m1 request presented in the very next cycle.
        t = cyc;
        start_req(0, 11'h7A5, t + 3 + TMO);
        wait_ack(0);
        @(negedge clk);
        req_v[0] = 1'b0;
        start_req(1, 11'h123, t + 22);
        wait_ack(1);
        @(negedge clk);
        req_v[1] = 1'b0;
        @(negedge clk);

        // Reset while the access sits in WAIT, then a fresh m1 request.
        t = cyc;
        start_req(0, 11'h601, -1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        req_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        start_req(1, 11'h0A4, cyc + 3);
        wait_ack(1);
        @(negedge clk);
        req_v[1] = 1'b0;

        // Back-to-back: new address presented the cycle after ack.
        t = cyc;
        start_req(0, 11'h055, t + 3);
        wait_ack(0);
        @(negedge clk);
        start_req(0, 11'h066, t + 7);
        wait_ack(0);
        @(negedge clk);
        req_v[0] = 1'b0;

        // Request dropped right after it was sampled still completes.
        t = cyc;
        start_req(0, 11'h0C3, t + 3);
        @(negedge clk);
        req_v[0] = 1'b0;
        wait_ack(0);
        @(negedge clk);

        // Slow ROM answering inside the window.
        t = cyc;
        start_req(1, 11'h603, t + 7);
        wait_ack(1);
        @(negedge clk);
        req_v[1] = 1'b0;
        @(negedge clk);

        // Randomised traffic from both masters.
        fork
            agent(0, 40);
            agent(1, 40);
        join
        repeat (5) @(negedge clk);
        chk("drain_m0", 64'(q0.size()), 64'd0);
        chk("drain_m1", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
